dice_result_tracker: RTL

Consumer end of the electronic dice: watches the `button` / `throw[2:0]` pair that the dice drives and detects the end of each roll (button release). It then latches the settled face, validates it, keeps per-face and total saturating roll counts, flags doubles, and drives a registered 7-segment pattern. It sits between the dice and the board display / LED logic, on the same clock.

---
 rtl/dice_result_tracker.sv | 95 +++++++++
 1 files changed

// File: rtl/dice_result_tracker.sv
// Watches the dice button/throw pair, captures the settled face after each release,
// validates it and maintains saturating roll statistics plus a registered 7-segment view.
module dice_result_tracker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic [2:0]       throw,
  input  logic [2:0]       face_sel,
  output logic [2:0]       result,
  output logic             result_valid,
  output logic             double,
  output logic             error,
  output logic [6:0]       seg,
  output logic [CNT_W-1:0] roll_count,
  output logic [CNT_W-1:0] face_count
);

  typedef enum logic [1:0] {StIdle, StRolling, StSettle} state_e;

  state_e           state_q, state_d;
  logic             button_q;
  logic             have_prev;
  logic             capture;
  logic             legal;
  logic [6:0]       seg_d;
  logic [CNT_W-1:0] face_cnt [6];

  // ROLLING is only entered or held with button sampled high, so button_q is always 1 there
  // and the falling-edge term is exactly the release condition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (button) state_d = StRolling;
      StRolling: if (button_q && !button) state_d = StSettle;
      StSettle:  state_d = button ? StRolling : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign capture = (state_q == StSettle);
  assign legal   = (throw != 3'd0) && (throw != 3'd7);

  always_comb begin
    seg_d = 7'h00;
    unique case (throw)
      3'd1:    seg_d = 7'h06;
      3'd2:    seg_d = 7'h5B;
      3'd3:    seg_d = 7'h4F;
      3'd4:    seg_d = 7'h66;
      3'd5:    seg_d = 7'h6D;
      3'd6:    seg_d = 7'h7D;
      default: seg_d = 7'h00;
    endcase
  end

  always_comb begin
    face_count = '0;
    for (int i = 0; i < 6; i++) begin
      if (face_sel == 3'(i + 1)) face_count = face_cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      button_q     <= 1'b0;
      result       <= 3'd0;
      result_valid <= 1'b0;
      double       <= 1'b0;
      error        <= 1'b0;
      have_prev    <= 1'b0;
      seg          <= 7'h00;
      roll_count   <= '0;
      for (int i = 0; i < 6; i++) face_cnt[i] <= '0;
    end else begin
      state_q      <= state_d;
      button_q     <= button;
      result_valid <= capture && legal;
      double       <= capture && legal && have_prev && (throw == result);
      if (capture && legal) begin
        result    <= throw;
        seg       <= seg_d;
        have_prev <= 1'b1;
        if (roll_count != '1) roll_count <= roll_count + CNT_W'(1);
        for (int i = 0; i < 6; i++) begin
          if (throw == 3'(i + 1) && face_cnt[i] != '1) face_cnt[i] <= face_cnt[i] + CNT_W'(1);
        end
      end
      if (capture && !legal) error <= 1'b1;
    end
  end

endmodule
